truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Synthesizable stimulus generator and response checker for a small combinational DUT; it sits on the far side of the DUT's pins.
- Drives every N_IN-bit input vector in ascending order and waits a fixed settle time after each one.
- Samples the DUT's 1-bit output and compares it against an expected truth table given as a parameter bitmask.
- Reports mismatch count, first failing vector and pass/done status, replacing a hand-written display bench with on-chip self-check.

Parameters:
- N_IN, 3, DUT input width; NUM_VEC = 2**N_IN vectors
- SETTLE, 10, clock cycles each vector is held before sampling (>=1)
- EXPECTED, 8'hA8, NUM_VEC-bit mask; bit i = expected DUT output for input vector i (default encodes E = C & (A | B), with vector = {A,B,C})

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a sweep
- dut_in  out  N_IN  vector driven to the DUT
- dut_out  in  1  DUT response
- busy  out  1  high while a sweep is running
- done  out  1  high after sweep completes, held until next start
- pass  out  1  valid when done; 1 iff err_count == 0
- err_count  out  $clog2(NUM_VEC+1)  number of mismatching vectors
- first_fail_valid  out  1  a mismatch has been recorded
- first_fail_vec  out  N_IN  lowest vector that mismatched

Behaviour:
- Reset (async, any state, including mid-sweep): state IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE / DONE with start=1:
  - vec<=0, settle counter<=0, err_count<=0, first_fail_valid<=0, done<=0, pass<=0, busy<=1, go to SETTLE.
  - dut_in always equals vec.
- SETTLE: counter increments each cycle; when counter == SETTLE-1, go to COMPARE.
- COMPARE (one cycle):
  - Sample dut_out and compare with EXPECTED[vec].
  - On mismatch: err_count++; if !first_fail_valid, then first_fail_vec<=vec and first_fail_valid<=1.
  - If vec == NUM_VEC-1: go to DONE, busy<=0, done<=1, pass<=(final err_count==0).
  - Else: vec<=vec+1, counter<=0, back to SETTLE.
- Timing: each vector occupies SETTLE+1 cycles; busy is high for exactly NUM_VEC*(SETTLE+1) cycles; done rises the cycle after the last COMPARE.
- start while busy is ignored; no restart and no counter disturbance.
- start in DONE restarts a sweep; previous results are cleared on that edge.
- err_count saturates at NUM_VEC (never wraps), which is reachable only when every vector fails.
- vec never wraps: the sweep terminates at NUM_VEC-1.
- dut_out is treated as already synchronous; any X on it counts as a mismatch in simulation.

Optional Feature:
- Macro: TT_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in COMPARE goes directly to DONE with pass=0 and err_count=1; dut_in holds the failing vector.
- Undefined: the full sweep always runs and counts all mismatches.

Decomposition:
- Package tt_check_pkg holds:
  - state enum tt_state_e {IDLE, SETTLE, COMPARE, DONE}
  - function num_vec(n) returning 2**n
  - function cnt_w(n) returning $clog2(2**n+1)
- One sub-module, settle_timer: a clear/enable counter with a terminal flag at SETTLE-1. It is instantiated once; the FSM and comparison stay in the top.

Test Plan:
- Reset, then start with a correct DUT (E = C&(A|B)) -> dut_in steps 0..7; busy high for 88 cycles; done=1, pass=1, err_count=0, first_fail_valid=0.
- DUT output forced to constant 0 -> done=1, pass=0, err_count=3, first_fail_vec=3.
- DUT output inverted -> err_count=8 (saturation limit reached, no wrap), first_fail_vec=0.
- start pulsed again at cycle 30 of a sweep -> ignored; the sweep still ends at cycle 88 with unchanged results. Then start in DONE -> done falls, err_count clears, new sweep runs.
- rst asserted mid-sweep at vec=4 -> all outputs return to 0 immediately (async); the next start sweeps from vec 0.
- With TT_CHECK_STOP_ON_FAIL_EN and constant-0 DUT -> done after 4*(SETTLE+1)=44 cycles; pass=0, err_count=1, dut_in=3.

Source files
------------

// File: rtl/tt_check_pkg.sv
// Shared types and sizing helpers for the truth-table checker.
// Holds the sweep FSM state enum and vector/count width functions.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMPARE,
    DONE
  } tt_state_e;

  function automatic int num_vec(input int n);
    return 2 ** n;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2((2 ** n) + 1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: clr zeroes it, en advances it, tc flags SETTLE-1.
// Ports: clk, rst (async high), clr, en in; tc out.
module settle_timer #(
  parameter int SETTLE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] LAST = TW'(SETTLE - 1);

  logic [TW-1:0] cnt;

  assign tc = (cnt == LAST);

  // Holds at the terminal value so a late en never wraps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all N_IN-bit vectors into a DUT, checks dut_out against EXPECTED.
// Ports: clk, rst, start, dut_out in; dut_in, busy, done, pass,
// err_count, first_fail_valid, first_fail_vec out.
// Macro TT_CHECK_STOP_ON_FAIL_EN: end the sweep on the first mismatch.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE = 10,
  parameter logic [(2**N_IN)-1:0] EXPECTED = 'hA8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [N_IN-1:0]            dut_in,
  input  logic                       dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [cnt_w(N_IN)-1:0]     err_count,
  output logic                       first_fail_valid,
  output logic [N_IN-1:0]            first_fail_vec
);

  localparam int NUM_VEC = num_vec(N_IN);
  localparam int CW = cnt_w(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);
  localparam logic [CW-1:0] ERR_MAX = CW'(NUM_VEC);

  tt_state_e state, nxt;
  logic [N_IN-1:0] vec;
  logic tc, tmr_clr, tmr_en;
  logic launch, cmp, stop;
  logic exp_bit, mismatch, last;
  logic [CW-1:0] err_nxt, err_fin;

  assign dut_in = vec;
  assign exp_bit = EXPECTED[vec];
  // Case equality so an X response counts as a mismatch.
  assign mismatch = !(dut_out === exp_bit);
  assign last = (vec == LAST_VEC);
  assign err_nxt = (err_count == ERR_MAX) ? err_count
                                          : err_count + CW'(1);
  assign err_fin = mismatch ? err_nxt : err_count;

`ifdef TT_CHECK_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    launch = 1'b0;
    cmp = 1'b0;
    tmr_en = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          launch = 1'b1;
          nxt = tt_check_pkg::SETTLE;
        end
      end
      tt_check_pkg::SETTLE: begin
        tmr_en = 1'b1;
        if (tc) nxt = COMPARE;
      end
      COMPARE: begin
        cmp = 1'b1;
        if (last || stop) nxt = DONE;
        else              nxt = tt_check_pkg::SETTLE;
      end
      default: nxt = IDLE;
    endcase
    tmr_clr = launch | cmp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec <= '0;
    end else if (launch) begin
      vec <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_valid <= 1'b0;
    end else if (cmp) begin
      if (mismatch) begin
        err_count <= err_nxt;
        if (!first_fail_valid) begin
          first_fail_vec <= vec;
          first_fail_valid <= 1'b1;
        end
      end
      if (last || stop) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_fin == '0);
      end else begin
        vec <= vec + N_IN'(1);
      end
    end
  end

endmodule
